hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipelined RISC-V core. Drives the stall (hold) and flush (clear) inputs of every pipeline latch, generates the EX-stage operand forwarding selects, and owns the request/acknowledge handshake to data memory for the instruction in MEM. A hold input of 1 freezes a latch; a clear input of 1 zeroes it on the next edge.

## Interface
- No parameters (register-index width fixed at 5, counter width fixed at 32).
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Rs1D`, `Rs2D` in 5 each: source registers in DECODE.
- `Rs1E`, `Rs2E`, `RdE` in 5 each: sources and destination in EXECUTE.
- `LoadE` in 1: instruction in EXECUTE is a load.
- `PCSrcE` in 1: branch taken, or jal/jalr resolved in EXECUTE.
- `RdM`, `RdW` in 5 each: destinations in MEMORY and WRITEBACK.
- `RegWriteM`, `RegWriteW` in 1 each: register-file write enables in MEMORY and WRITEBACK.
- `MemAccessM` in 1: instruction in MEMORY is a load or a store.
- `dmem_ack` in 1: one-cycle completion pulse from data memory.
- `dmem_req` out 1: data-memory request, held until `dmem_ack`.
- `StallF`, `StallD`, `StallE`, `StallM` out 1 each: hold PC, F/D, D/E, and E/M latches.
- `FlushD`, `FlushE`, `FlushW` out 1 each: clear F/D, D/E, and M/W latches.
- `ForwardAE`, `ForwardBE` out 2 each: EX operand select. 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `perf_stall_cycles`, `perf_flushes` out 32 each: present only with `HAZARD_PERF_EN`.

## Operation
**Forwarding (combinational)**
- `ForwardAE` = 10 if `RegWriteM` && `RdM`≠0 && `RdM`==`Rs1E`.
- Otherwise 01 if `RegWriteW` && `RdW`≠0 && `RdW`==`Rs1E`.
- Otherwise 00.
- MEM match wins over WB match. `ForwardBE` follows the same rule using `Rs2E`.

**Memory FSM, states IDLE and WAIT**
- IDLE, `MemAccessM`=0: `dmem_req`=0, no memory stall.
- IDLE, `MemAccessM`=1: `dmem_req`=1.
  - `dmem_ack` in the same cycle: no stall, remain in IDLE.
  - No `dmem_ack`: memStall=1, go to WAIT.
- WAIT: `dmem_req`=1, memStall=1 until `dmem_ack`.
  - In the `dmem_ack` cycle: memStall=0 and the state returns to IDLE, so the pipeline advances on that edge.
  - The request is never re-issued for the same instruction.
- `dmem_ack` while in IDLE with `MemAccessM`=0: ignored.

**Hazard terms**
- lwStall = `LoadE` && `RdE`≠0 && (`RdE`==`Rs1D` || `RdE`==`Rs2D`).

**Priority, highest first**
1. memStall: `StallF`=`StallD`=`StallE`=`StallM`=1, `FlushW`=1, `FlushD`=`FlushE`=0. Any redirect or load-use bubble is deferred because EXECUTE is held and `PCSrcE` persists.
2. `PCSrcE`: `FlushD`=`FlushE`=1, all stalls 0. The wrong-path load-use is discarded.
3. lwStall: `StallF`=`StallD`=1, `FlushE`=1.
4. Otherwise all stalls and flushes are 0.

## Timing
- Stall, flush, and forward outputs are combinational from inputs and FSM state; there is no added latency.
- FSM state and perf counters are registered on `posedge clk`.
- Minimum memory access costs 0 stall cycles (ack in the request cycle). An ack N cycles after the request costs N stall cycles.
- Reset values while `rst_n`=0 (asynchronous, immediate):
  - FSM in IDLE, `dmem_req`=0.
  - All Stall outputs = 0.
  - `FlushD`=`FlushE`=`FlushW`=1.
  - Forward outputs = 00.
  - Counters = 0.
- Reset deasserted mid-WAIT: the FSM restarts in IDLE and the outstanding request is abandoned. Data memory is reset by the same `rst_n`.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `perf_stall_cycles` increments on every cycle with any Stall output high.
  - `perf_flushes` increments on every cycle with `FlushD` or `FlushE` high.
  - Both counters saturate at 0xFFFFFFFF.
- `HAZARD_PERF_EN` undefined: both counter ports and their logic are absent.

## Structure
- Shared package holds the forward encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the FSM state encodings IDLE=1'b0, WAIT=1'b1.
- One sub-module, `hazard_forward`: the combinational forwarding comparator, instantiated twice (operand A and operand B).

## Test plan
- `RegWriteM`=1, `RdM`=5, `Rs1E`=5, and `RegWriteW`=1, `RdW`=5 → `ForwardAE`=10. Repeat with `RdM`=0 → `ForwardAE`=01.
- `LoadE`=1, `RdE`=7, `Rs2D`=7 → `StallF`=`StallD`=`FlushE`=1 for exactly one cycle. Repeat with `RdE`=0 → no stall.
- `MemAccessM`=1 with `dmem_ack` 3 cycles later → `dmem_req` high for 4 cycles, memStall for 3 cycles, FSM returns to IDLE.
- `PCSrcE`=1 and lwStall in the same cycle → `FlushD`=`FlushE`=1, `StallF`=0.
- `PCSrcE`=1 during WAIT → no flush until the ack cycle, then `FlushD`=`FlushE`=1.
- `rst_n` pulled low mid-WAIT → `dmem_req`=0 immediately, `FlushD`=`FlushE`=`FlushW`=1, counters cleared (with `HAZARD_PERF_EN`).

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the hazard controller:
//   - register-index and counter widths
//   - EX operand forwarding select encodings
//   - data-memory handshake FSM state encoding
//   - saturating increment helper for the optional perf counters
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // EX operand select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // MEM ALU result

  // Data-memory handshake FSM
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundles every pipeline-side and data-memory-side signal of the hazard
// controller. clk/rst_n are kept outside as plain ports.
//   master : view of the controller (pipeline info in, stall/flush/fwd out)
//   slave  : view of the pipeline / memory environment driving the controller
// Optional macro HAZARD_PERF_EN adds perf_stall_cycles / perf_flushes.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0] Rs1D, Rs2D;
  logic [REG_W-1:0] Rs1E, Rs2E, RdE;
  logic             LoadE;
  logic             PCSrcE;
  logic [REG_W-1:0] RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic             MemAccessM;
  logic             dmem_ack;
  logic             dmem_req;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_cycles;
  logic [CNT_W-1:0] perf_flushes;

  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, LoadE, PCSrcE, RdM, RdW,
           RegWriteM, RegWriteW, MemAccessM, dmem_ack,
    output dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, perf_stall_cycles, perf_flushes
  );

  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, LoadE, PCSrcE, RdM, RdW,
           RegWriteM, RegWriteW, MemAccessM, dmem_ack,
    input  dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, perf_stall_cycles, perf_flushes
  );
`else
  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, LoadE, PCSrcE, RdM, RdW,
           RegWriteM, RegWriteW, MemAccessM, dmem_ack,
    output dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE
  );

  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, LoadE, PCSrcE, RdM, RdW,
           RegWriteM, RegWriteW, MemAccessM, dmem_ack,
    input  dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE
  );
`endif

endinterface

// File: rtl/hazard_ctrl_forward.sv
// hazard_forward
// Combinational forwarding comparator for one EX source operand.
// Ports:
//   i_rs_e        : source register in EXECUTE
//   i_rd_m/i_rd_w : destinations in MEMORY / WRITEBACK
//   i_reg_write_m/i_reg_write_w : write enables in MEMORY / WRITEBACK
//   o_fwd         : operand select (FWD_RF / FWD_WB / FWD_MEM)
module hazard_forward
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_rs_e,
  input  logic [REG_W-1:0] i_rd_m,
  input  logic [REG_W-1:0] i_rd_w,
  input  logic             i_reg_write_m,
  input  logic             i_reg_write_w,
  output logic [1:0]       o_fwd
);

  // Select the youngest in-flight producer; x0 is never forwarded
  always_comb begin
    o_fwd = FWD_RF;
    if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs_e)) begin
      o_fwd = FWD_MEM;
    end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs_e)) begin
      o_fwd = FWD_WB;
    end else begin
      o_fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard and sequencing controller for the 5-stage RISC-V pipeline: latch
// stall/flush control, EX operand forwarding selects and the data-memory
// request/acknowledge handshake for the instruction in MEM.
// Ports:
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_ctrl_if.master (pipeline hazard info, dmem handshake,
//           stall/flush/forward outputs, optional perf counters)
// Optional macro HAZARD_PERF_EN: adds saturating stall-cycle and flush-cycle
// counters on bus.perf_stall_cycles / bus.perf_flushes.
// All control outputs are combinational; only the FSM state and the perf
// counters are registered. While rst_n is low the outputs take their reset
// values immediately (flushes high, everything else low).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.master bus
);

  mem_state_e r_state;
  mem_state_e w_state_nxt;
  logic       w_mem_req;
  logic       w_mem_stall;
  logic       w_lw_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic       w_flush_d, w_flush_e, w_flush_w;
  logic       w_dmem_req;
  logic [1:0] w_fwd_a_out, w_fwd_b_out;

  hazard_forward u_fwd_a (
    .i_rs_e        (bus.Rs1E),
    .i_rd_m        (bus.RdM),
    .i_rd_w        (bus.RdW),
    .i_reg_write_m (bus.RegWriteM),
    .i_reg_write_w (bus.RegWriteW),
    .o_fwd         (w_fwd_a)
  );

  hazard_forward u_fwd_b (
    .i_rs_e        (bus.Rs2E),
    .i_rd_m        (bus.RdM),
    .i_rd_w        (bus.RdW),
    .i_reg_write_m (bus.RegWriteM),
    .i_reg_write_w (bus.RegWriteW),
    .o_fwd         (w_fwd_b)
  );

  // Memory FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory FSM next state, request and memory stall.
  // The ack cycle itself is not a stall so the pipeline advances on that edge;
  // leaving WAIT only on ack means the request is issued exactly once.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_mem_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.MemAccessM) begin
          w_mem_req = 1'b1;
          if (bus.dmem_ack) begin
            w_state_nxt = IDLE;
          end else begin
            w_mem_stall = 1'b1;
            w_state_nxt = WAIT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        w_mem_req = 1'b1;
        if (bus.dmem_ack) begin
          w_state_nxt = IDLE;
        end else begin
          w_mem_stall = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_lw_stall = bus.LoadE && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // Stall/flush priority: memory stall, then redirect, then load-use bubble.
  // A held EX keeps PCSrcE/load-use alive, so they resolve after the memory stall.
  always_comb begin
    w_stall_f  = 1'b0;
    w_stall_d  = 1'b0;
    w_stall_e  = 1'b0;
    w_stall_m  = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_e  = 1'b0;
    w_flush_w  = 1'b0;
    w_dmem_req = 1'b0;
    w_fwd_a_out = FWD_RF;
    w_fwd_b_out = FWD_RF;
    if (!rst_n) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_w = 1'b1;
    end else begin
      w_dmem_req  = w_mem_req;
      w_fwd_a_out = w_fwd_a;
      w_fwd_b_out = w_fwd_b;
      if (w_mem_stall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;  // M/W gets a bubble while MEM is held
      end else if (bus.PCSrcE) begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_lw_stall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end else begin
        w_flush_w = 1'b0;
      end
    end
  end

  assign bus.dmem_req  = w_dmem_req;
  assign bus.StallF    = w_stall_f;
  assign bus.StallD    = w_stall_d;
  assign bus.StallE    = w_stall_e;
  assign bus.StallM    = w_stall_m;
  assign bus.FlushD    = w_flush_d;
  assign bus.FlushE    = w_flush_e;
  assign bus.FlushW    = w_flush_w;
  assign bus.ForwardAE = w_fwd_a_out;
  assign bus.ForwardBE = w_fwd_b_out;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_flush;
  logic             w_any_stall;
  logic             w_any_flush;

  assign w_any_stall = w_stall_f | w_stall_d | w_stall_e | w_stall_m;
  assign w_any_flush = w_flush_d | w_flush_e;

  // Saturating stall-cycle and flush-cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= {CNT_W{1'b0}};
      r_perf_flush <= {CNT_W{1'b0}};
    end else begin
      if (w_any_stall) begin
        r_perf_stall <= sat_inc(r_perf_stall);
      end else begin
        r_perf_stall <= r_perf_stall;
      end
      if (w_any_flush) begin
        r_perf_flush <= sat_inc(r_perf_flush);
      end else begin
        r_perf_flush <= r_perf_flush;
      end
    end
  end

  assign bus.perf_stall_cycles = r_perf_stall;
  assign bus.perf_flushes      = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed and randomized stimulus for hazard_ctrl, checked against a
// behavioural model that works from the controller's rules: which older
// instruction produces a source, whether a memory access is still owed an
// ack, and which hazard wins. Outputs are sampled 1 time unit after inputs
// change at the falling edge; the model advances on the rising edge.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: an access has been requested and no ack has arrived yet
  bit          m_outstanding;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;
  // Expectations of the current cycle, used to advance the model
  bit          e_req, e_any_stall, e_any_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest writer of register rs among MEM then WB; x0 never forwarded
  function automatic logic [1:0] producer(input logic [4:0] rs);
    if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == rs) return 2'b10;
    if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic settle(input string tag);
    logic [1:0] fa, fb;
    bit mem_wait, load_use;
    bit sf, sd, se, sm, fd, fe, fw;
    #1;
    fa = 2'b00; fb = 2'b00;
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0;
    e_req = 0;
    if (!rst_n) begin
      fd = 1; fe = 1; fw = 1;
    end else begin
      fa = producer(bus.Rs1E);
      fb = producer(bus.Rs2E);
      e_req    = m_outstanding || bus.MemAccessM;
      mem_wait = e_req && !bus.dmem_ack;
      load_use = bus.LoadE && bus.RdE != 5'd0 &&
                 (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
      if (mem_wait) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end else if (bus.PCSrcE) begin
        fd = 1; fe = 1;
      end else if (load_use) begin
        sf = 1; sd = 1; fe = 1;
      end
    end
    e_any_stall = sf | sd | se | sm;
    e_any_flush = fd | fe;
    chk({tag, ":dmem_req"},  32'(bus.dmem_req),  32'(e_req));
    chk({tag, ":StallF"},    32'(bus.StallF),    32'(sf));
    chk({tag, ":StallD"},    32'(bus.StallD),    32'(sd));
    chk({tag, ":StallE"},    32'(bus.StallE),    32'(se));
    chk({tag, ":StallM"},    32'(bus.StallM),    32'(sm));
    chk({tag, ":FlushD"},    32'(bus.FlushD),    32'(fd));
    chk({tag, ":FlushE"},    32'(bus.FlushE),    32'(fe));
    chk({tag, ":FlushW"},    32'(bus.FlushW),    32'(fw));
    chk({tag, ":ForwardAE"}, 32'(bus.ForwardAE), 32'(fa));
    chk({tag, ":ForwardBE"}, 32'(bus.ForwardBE), 32'(fb));
`ifdef HAZARD_PERF_EN
    chk({tag, ":perf_stall"}, bus.perf_stall_cycles, m_stall_cnt);
    chk({tag, ":perf_flush"}, bus.perf_flushes,      m_flush_cnt);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      m_outstanding = 0;
      m_stall_cnt   = 32'd0;
      m_flush_cnt   = 32'd0;
    end else begin
      m_outstanding = e_req && !bus.dmem_ack;
      if (e_any_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
      if (e_any_flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
    bus.RdE = 5'd0; bus.RdM = 5'd0; bus.RdW = 5'd0;
    bus.LoadE = 1'b0; bus.PCSrcE = 1'b0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
    bus.MemAccessM = 1'b0; bus.dmem_ack = 1'b0;
  endtask

  // Small register range so that matches are frequent
  task automatic random_inputs();
    bus.Rs1D = 5'($urandom_range(0, 3)); bus.Rs2D = 5'($urandom_range(0, 3));
    bus.Rs1E = 5'($urandom_range(0, 3)); bus.Rs2E = 5'($urandom_range(0, 3));
    bus.RdE  = 5'($urandom_range(0, 3)); bus.RdM  = 5'($urandom_range(0, 3));
    bus.RdW  = 5'($urandom_range(0, 3));
    bus.LoadE      = 1'($urandom_range(0, 1));
    bus.PCSrcE     = ($urandom_range(0, 3) == 0);
    bus.RegWriteM  = 1'($urandom_range(0, 1));
    bus.RegWriteW  = 1'($urandom_range(0, 1));
    bus.MemAccessM = ($urandom_range(0, 2) == 0);
    bus.dmem_ack   = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    m_outstanding = 0;
    m_stall_cnt   = 32'd0;
    m_flush_cnt   = 32'd0;
    rst_n = 1'b0;
    clear_inputs();
    // Activity on the inputs must not leak through while reset is held
    bus.MemAccessM = 1'b1; bus.RegWriteM = 1'b1; bus.RdM = 5'd3; bus.Rs1E = 5'd3;
    bus.LoadE = 1'b1; bus.RdE = 5'd2; bus.Rs1D = 5'd2;
    @(negedge clk);
    settle("reset");
    chk("reset_FlushW", 32'(bus.FlushW), 32'd1);
    chk("reset_req",    32'(bus.dmem_req), 32'd0);
    advance();
    rst_n = 1'b1;
    clear_inputs();
    settle("idle");
    advance();

    // MEM wins over WB, then WB when MEM targets x0
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5;
    bus.RegWriteW = 1'b1; bus.RdW = 5'd5;
    settle("fwd_mem");
    chk("fwd_mem_AE", 32'(bus.ForwardAE), 32'd2);
    advance();
    bus.RdM = 5'd0;
    settle("fwd_wb");
    chk("fwd_wb_AE", 32'(bus.ForwardAE), 32'd1);
    bus.Rs2E = 5'd5; bus.Rs1E = 5'd6;
    settle("fwd_b");
    chk("fwd_b_BE", 32'(bus.ForwardBE), 32'd1);
    advance();

    // Load-use: one bubble, then the load moves on
    clear_inputs();
    bus.LoadE = 1'b1; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    settle("lw");
    chk("lw_StallF", 32'(bus.StallF), 32'd1);
    chk("lw_FlushE", 32'(bus.FlushE), 32'd1);
    advance();
    bus.LoadE = 1'b0;
    settle("lw_after");
    chk("lw_after_StallF", 32'(bus.StallF), 32'd0);
    advance();
    bus.LoadE = 1'b1; bus.RdE = 5'd0; bus.Rs2D = 5'd0;
    settle("lw_x0");
    chk("lw_x0_StallF", 32'(bus.StallF), 32'd0);
    advance();

    // Memory access acked 3 cycles after request: 4 req cycles, 3 stalls
    clear_inputs();
    bus.MemAccessM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle("mem_wait");
      chk("mem_wait_req",    32'(bus.dmem_req), 32'd1);
      chk("mem_wait_StallM", 32'(bus.StallM),   32'd1);
      advance();
    end
    bus.dmem_ack = 1'b1;
    settle("mem_ack");
    chk("mem_ack_req",    32'(bus.dmem_req), 32'd1);
    chk("mem_ack_StallM", 32'(bus.StallM),   32'd0);
    advance();
    clear_inputs();
    settle("mem_idle");
    chk("mem_idle_req", 32'(bus.dmem_req), 32'd0);
    advance();
    // Zero-latency access
    bus.MemAccessM = 1'b1; bus.dmem_ack = 1'b1;
    settle("mem_fast");
    chk("mem_fast_StallF", 32'(bus.StallF), 32'd0);
    advance();

    // Redirect beats load-use
    clear_inputs();
    bus.PCSrcE = 1'b1; bus.LoadE = 1'b1; bus.RdE = 5'd4; bus.Rs1D = 5'd4;
    settle("br_lw");
    chk("br_lw_FlushD", 32'(bus.FlushD), 32'd1);
    chk("br_lw_StallF", 32'(bus.StallF), 32'd0);
    advance();

    // Redirect during a memory wait is deferred to the ack cycle
    clear_inputs();
    bus.MemAccessM = 1'b1; bus.PCSrcE = 1'b1;
    settle("br_wait0");
    chk("br_wait0_FlushD", 32'(bus.FlushD), 32'd0);
    advance();
    settle("br_wait1");
    chk("br_wait1_FlushE", 32'(bus.FlushE), 32'd0);
    advance();
    bus.dmem_ack = 1'b1;
    settle("br_ack");
    chk("br_ack_FlushD", 32'(bus.FlushD), 32'd1);
    chk("br_ack_FlushE", 32'(bus.FlushE), 32'd1);
    advance();

    // Reset in the middle of a wait abandons the request
    clear_inputs();
    bus.MemAccessM = 1'b1;
    settle("rst_wait0");
    advance();
    settle("rst_wait1");
    rst_n = 1'b0;
    settle("rst_mid");
    chk("rst_mid_req",    32'(bus.dmem_req), 32'd0);
    chk("rst_mid_FlushD", 32'(bus.FlushD),   32'd1);
    advance();
    rst_n = 1'b1;
    bus.MemAccessM = 1'b0;
    settle("rst_after");
    chk("rst_after_req", 32'(bus.dmem_req), 32'd0);
    advance();

    // Randomized traffic, including occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      random_inputs();
      settle("rnd");
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
